// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit and its load aligner.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsuStateT;

  // Unshifted byte-enable pattern; the caller narrows it to its bus width.
  function automatic logic [7:0] beMask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: beMask = 8'h01;
      SIZE_HALF: beMask = 8'h03;
      SIZE_WORD: beMask = 8'h0F;
      default:   beMask = 8'hFF;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] addrLow);
    case (size)
      SIZE_BYTE: isMisaligned = 1'b0;
      SIZE_HALF: isMisaligned = addrLow[0];
      SIZE_WORD: isMisaligned = |addrLow[1:0];
      default:   isMisaligned = |addrLow;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Shifts the addressed lane down to bit 0 and sign/zero-extends it to DATA_W.
module load_aligner
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             rdata,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [1:0]                    size,
  input  logic                          isUnsigned,
  output logic [DATA_W-1:0]             loadData
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] keepMask;
  logic              signBit;

  assign lane = rdata >> {offset, 3'b000};

  // A full-width access keeps every bit, so ~keepMask is zero and no extension happens.
  always_comb begin
    keepMask = '1;
    signBit  = 1'b0;
    case (size)
      SIZE_BYTE: begin
        keepMask = DATA_W'(8'hFF);
        signBit  = lane[7];
      end
      SIZE_HALF: begin
        keepMask = DATA_W'(16'hFFFF);
        signBit  = lane[15];
      end
      SIZE_WORD: begin
        keepMask = DATA_W'(32'hFFFF_FFFF);
        signBit  = lane[31];
      end
      default: begin
        keepMask = '1;
        signBit  = 1'b0;
      end
    endcase
    loadData = (lane & keepMask) | ((signBit && !isUnsigned) ? ~keepMask : '0);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores, runs the memory handshake
// with an optional timeout and returns one writeback response per request.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | strobes asserted, waiting for mem_ack_in or timeout
// RESP   | one-cycle writeback response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic                req_we_in,
  input  logic [ADDR_W-1:0]   req_addr_in,
  input  logic [DATA_W-1:0]   req_wdata_in,
  input  logic [1:0]          req_size_in,
  input  logic                req_unsigned_in,
  input  logic [4:0]          req_rd_in,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [DATA_W-1:0]   mem_wdata_out,
  output logic [DATA_W/8-1:0] mem_be_out,
  output logic                mem_re_out,
  output logic                mem_we_out,
  input  logic                mem_ack_in,
  input  logic [DATA_W-1:0]   mem_rdata_in,
  output logic                resp_valid_out,
  output logic                resp_load_out,
  output logic [DATA_W-1:0]   resp_data_out,
  output logic [4:0]          resp_rd_out,
  output logic [1:0]          resp_err_out
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0]  TIMEOUT_CNT = TMR_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LANE_MASK   = ADDR_W'(BE_W - 1);

  lsuStateT          state, stateNext;
  logic              accept, ackHit, timeoutHit;
  logic [TMR_W-1:0]  timer, timerInc;

  logic              reqWe, reqUnsigned;
  logic [1:0]        reqSize;
  logic [4:0]        reqRd;
  logic [OFF_W-1:0]  reqOffset;

  logic [1:0]        inSize;
  logic              inMisaligned;
  logic [DATA_W-1:0] wdataRep, loadData;
  logic [BE_W-1:0]   beNext;

  // A 32-bit bus has no dword lane, so dword requests behave as words from here on.
  assign inSize       = (DATA_W == 32 && req_size_in == SIZE_DWORD) ? SIZE_WORD : req_size_in;
  assign inMisaligned = isMisaligned(inSize, req_addr_in[2:0]);
  assign beNext       = BE_W'(beMask(inSize)) << req_addr_in[OFF_W-1:0];
  assign timerInc     = timer + TMR_W'(1);
  assign req_ready_out = (state == IDLE);

  always_comb begin
    case (inSize)
      SIZE_BYTE: wdataRep = {BE_W{req_wdata_in[7:0]}};
      SIZE_HALF: wdataRep = {(BE_W/2){req_wdata_in[15:0]}};
      SIZE_WORD: wdataRep = {(DATA_W/32){req_wdata_in[31:0]}};
      default:   wdataRep = req_wdata_in;
    endcase
  end

  load_aligner #(.DATA_W(DATA_W)) aligner (
    .rdata      (mem_rdata_in),
    .offset     (reqOffset),
    .size       (reqSize),
    .isUnsigned (reqUnsigned),
    .loadData   (loadData)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    ackHit     = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_in) begin
          accept    = 1'b1;
          stateNext = inMisaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack_in) begin
          ackHit    = 1'b1;
          stateNext = RESP;
        end else if (TIMEOUT != 0 && timerInc == TIMEOUT_CNT) begin
          timeoutHit = 1'b1;
          stateNext  = RESP;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer          <= '0;
      reqWe          <= 1'b0;
      reqUnsigned    <= 1'b0;
      reqSize        <= SIZE_BYTE;
      reqRd          <= '0;
      reqOffset      <= '0;
      mem_addr_out   <= '0;
      mem_wdata_out  <= '0;
      mem_be_out     <= '0;
      mem_re_out     <= 1'b0;
      mem_we_out     <= 1'b0;
      resp_valid_out <= 1'b0;
      resp_load_out  <= 1'b0;
      resp_data_out  <= '0;
      resp_rd_out    <= '0;
      resp_err_out   <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            timer       <= '0;
            reqWe       <= req_we_in;
            reqUnsigned <= req_unsigned_in;
            reqSize     <= inSize;
            reqRd       <= req_rd_in;
            reqOffset   <= req_addr_in[OFF_W-1:0];
            if (inMisaligned) begin
              resp_valid_out <= 1'b1;
              resp_load_out  <= !req_we_in;
              resp_data_out  <= '0;
              resp_rd_out    <= req_rd_in;
              resp_err_out   <= ERR_MISALIGN;
            end else begin
              mem_addr_out  <= req_addr_in & ~LANE_MASK;
              mem_wdata_out <= wdataRep;
              mem_be_out    <= beNext;
              mem_re_out    <= !req_we_in;
              mem_we_out    <= req_we_in;
            end
          end
        end
        ACCESS: begin
          timer <= timerInc;
          if (ackHit || timeoutHit) begin
            mem_addr_out   <= '0;
            mem_wdata_out  <= '0;
            mem_be_out     <= '0;
            mem_re_out     <= 1'b0;
            mem_we_out     <= 1'b0;
            resp_valid_out <= 1'b1;
            resp_load_out  <= !reqWe;
            resp_data_out  <= (ackHit && !reqWe) ? loadData : '0;
            resp_rd_out    <= reqRd;
            resp_err_out   <= ackHit ? ERR_NONE : ERR_TIMEOUT;
          end
        end
        default: begin
          resp_valid_out <= 1'b0;
          resp_load_out  <= 1'b0;
          resp_data_out  <= '0;
          resp_rd_out    <= '0;
          resp_err_out   <= ERR_NONE;
        end
      endcase
    end
  end

endmodule
